// File: rtl/output_unit.sv
// output_unit: result display path of the calculator.
// Takes an 8-bit two's-complement result and converts it to sign-magnitude.
// A sequential double-dabble engine (one iteration per clock) turns the
// magnitude into three BCD digits. The result drives a 4-digit multiplexed
// common-anode 7-segment display in the order sign, hundreds, tens, ones.
// An error request replaces the number with "Err".
//
// Handshake: a load is accepted only at a rising edge where load=1 and busy=0.
// TS and err are sampled at that same edge, and busy rises on it. Any load
// seen while busy=1 is dropped and is not queued. Exactly nine edges after
// acceptance, done pulses high for one cycle and busy falls on that same edge.
// The unit is then idle, so a load held high during the done cycle is accepted.
module output_unit #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] TS,
    input  logic       load,
    input  logic       err,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Symbol codes held in the display registers; 0..9 are the decimal digits.
    localparam logic [3:0] SYM_ZERO  = 4'd0;
    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_BLANK = 4'd11;
    localparam logic [3:0] SYM_E     = 4'd12;
    localparam logic [3:0] SYM_R     = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t          state;
    logic            neg;
    logic            err_flag;
    logic [7:0]      mag;
    logic [11:0]     bcd;
    logic [2:0]      iter;
    logic [3:0][3:0] disp;       // disp[3] = sign position, disp[0] = ones
    logic [CW-1:0]   scan_cnt;
    logic [1:0]      digit_idx;

    logic [11:0]     bcd_adj;
    logic [11:0]     bcd_next;
    logic [7:0]      mag_next;
    logic [3:0][3:0] disp_next;
    logic [3:0]      sym;

    // One double-dabble step: add 3 to each nibble >= 5, then shift {bcd, mag} left by one.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[10:0], mag[7]};
        mag_next = {mag[6:0], 1'b0};
    end

    // Compose the display symbols from the finished BCD value with leading-zero blanking.
    // A negative input always has a non-zero magnitude (0x80 becomes 128), so neg alone selects the minus sign.
    always_comb begin
        disp_next = {SYM_BLANK, SYM_BLANK, SYM_BLANK, SYM_ZERO};
        if (err_flag) begin
            disp_next = {SYM_BLANK, SYM_E, SYM_R, SYM_R};
        end else begin
            disp_next[3] = neg ? SYM_MINUS : SYM_BLANK;
            disp_next[2] = (bcd[11:8] == 4'd0) ? SYM_BLANK : bcd[11:8];
            disp_next[1] = ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) ? SYM_BLANK : bcd[7:4];
            disp_next[0] = bcd[3:0];
        end
    end

    // Control FSM: capture on load, run eight conversion steps, then publish to the display.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            neg      <= 1'b0;
            err_flag <= 1'b0;
            mag      <= 8'd0;
            bcd      <= 12'd0;
            iter     <= 3'd0;
            disp     <= {SYM_BLANK, SYM_BLANK, SYM_BLANK, SYM_ZERO};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        neg      <= TS[7];
                        err_flag <= err;
                        mag      <= TS[7] ? (~TS + 8'd1) : TS;
                        bcd      <= 12'd0;
                        iter     <= 3'd0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_next;
                    mag  <= mag_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= UPD;
                    end
                end
                UPD: begin
                    disp  <= disp_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan: hold each digit for REFRESH_DIV clocks, then step to the next digit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Decode the selected display register to active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        sym = disp[digit_idx];
        an  = ~(4'b0001 << digit_idx);
        case (sym)
            4'd0:      seg = 7'b1000000;
            4'd1:      seg = 7'b1111001;
            4'd2:      seg = 7'b0100100;
            4'd3:      seg = 7'b0110000;
            4'd4:      seg = 7'b0011001;
            4'd5:      seg = 7'b0010010;
            4'd6:      seg = 7'b0000010;
            4'd7:      seg = 7'b1111000;
            4'd8:      seg = 7'b0000000;
            4'd9:      seg = 7'b0010000;
            SYM_MINUS: seg = 7'b0111111;
            SYM_E:     seg = 7'b0000110;
            SYM_R:     seg = 7'b0101111;
            default:   seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_output_unit.sv
// Testbench for output_unit: randomized and directed loads are checked every
// cycle against a behavioural model of the display path.
module tb_output_unit;

    localparam int DIV = 4;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_R     = 7'b0101111;

    // ---------------- clock / reset / DUT ----------------
    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       load = 1'b0;
    logic       err  = 1'b0;
    logic [7:0] ts   = 8'd0;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;

    always #5 clk = ~clk;

    output_unit #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .TS   (ts),
        .load (load),
        .err  (err),
        .busy (busy),
        .done (done),
        .seg  (seg),
        .an   (an)
    );

    // ---------------- model state ----------------
    int          vectors    = 0;
    int          miscompares = 0;
    int          done_cnt   = 0;
    bit          chk_en     = 1'b0;
    logic [27:0] exp_q[$];
    logic [27:0] m_word;
    logic [6:0]  m_disp[4];
    int          m_cnt  = 0;
    bit          m_done = 1'b0;
    int          m_scan = 0;
    int          m_idx  = 0;

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Expected display word for a value, worked out with plain decimal arithmetic.
    function automatic logic [27:0] expected_display(input logic [7:0] v, input logic e);
        int m, h, t, o;
        logic [6:0] d3, d2, d1;
        if (e) return pack4(S_BLANK, S_E, S_R, S_R);
        m = v[7] ? 256 - int'(v) : int'(v);
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        d3 = (v[7] && m != 0) ? S_MINUS : S_BLANK;
        d2 = (h == 0) ? S_BLANK : digit_code(h);
        d1 = (h == 0 && t == 0) ? S_BLANK : digit_code(t);
        return pack4(d3, d2, d1, digit_code(o));
    endfunction

    // Behavioural model: nine edges from acceptance to publication, with a free scan.
    always @(posedge clk) begin
        if (!rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_scan = 0;
            m_idx  = 0;
            exp_q.delete();
            m_disp[0] = digit_code(0);
            m_disp[1] = S_BLANK;
            m_disp[2] = S_BLANK;
            m_disp[3] = S_BLANK;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (load) begin
                    m_cnt = 9;
                    exp_q.push_back(expected_display(ts, err));
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_word = exp_q.pop_front();
                    for (int k = 0; k < 4; k++) m_disp[k] = m_word[k*7 +: 7];
                    m_done = 1'b1;
                end
            end
            if (m_scan == DIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % 4;
            end else begin
                m_scan++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("busy", {6'd0, busy}, {6'd0, (m_cnt != 0)});
            check("done", {6'd0, done}, {6'd0, m_done});
            check("an", {3'd0, an}, {3'd0, ~(4'b0001 << m_idx)});
            check("seg", seg, m_disp[m_idx]);
            if (done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_display(input logic [27:0] lit);
        for (int k = 0; k < 4; k++) check("model_pin", m_disp[k], lit[k*7 +: 7]);
        repeat (4 * DIV) begin
            @(posedge clk);
            #1;
            check("disp_lit", seg, lit[m_idx*7 +: 7]);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("load_timeout", {6'd0, seen}, 7'd1);
    endtask

    task automatic do_load(input logic [7:0] v, input logic e);
        @(negedge clk);
        ts = v; err = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b1;
        check_display(pack4(S_BLANK, S_BLANK, S_BLANK, 7'b1000000));

        do_load(8'hF3, 1'b0);
        check_display(pack4(S_MINUS, S_BLANK, 7'b1111001, 7'b0110000));
        do_load(8'h80, 1'b0);
        check_display(pack4(S_MINUS, 7'b1111001, 7'b0100100, 7'b0000000));
        do_load(8'h7F, 1'b0);
        check_display(pack4(S_BLANK, 7'b1111001, 7'b0100100, 7'b1111000));
        do_load(8'h00, 1'b0);
        check_display(pack4(S_BLANK, S_BLANK, S_BLANK, 7'b1000000));
        do_load(8'h05, 1'b1);
        check_display(pack4(S_BLANK, S_E, S_R, S_R));
        do_load(8'h05, 1'b0);
        check_display(pack4(S_BLANK, S_BLANK, S_BLANK, 7'b0010010));

        // A second load during a conversion is dropped.
        dc0 = done_cnt;
        @(negedge clk);
        ts = 8'h2A; err = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        ts = 8'h01; load = 1'b1;
        @(negedge clk);
        load = 1'b0; ts = 8'h2A;
        wait_done();
        repeat (12) @(negedge clk);
        check("done_pulses", 7'(done_cnt - dc0), 7'd1);
        check_display(pack4(S_BLANK, S_BLANK, 7'b0011001, 7'b0100100));

        // Reset in the middle of a conversion aborts it.
        dc0 = done_cnt;
        @(negedge clk);
        ts = 8'h55; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("busy_after_rst", {6'd0, busy}, 7'd0);
        repeat (14) @(negedge clk);
        check("no_done_after_rst", 7'(done_cnt - dc0), 7'd0);
        check_display(pack4(S_BLANK, S_BLANK, S_BLANK, 7'b1000000));
        do_load(8'h9C, 1'b0);
        check_display(pack4(S_MINUS, 7'b1111001, 7'b1000000, 7'b1000000));

        // Randomized traffic: loads at random times, including while busy, plus rare resets.
        repeat (1500) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) != 0);
            load = ($urandom_range(0, 3) == 0);
            ts   = 8'($urandom);
            err  = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        rst = 1'b1; load = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
